// File: rtl/imsic_intp_file_rx.sv
// IMSIC interrupt-file receive side: MSI FIFO, pending bits and topei/xeip selection.
// One hart, one privilege level; EIID 0 is reserved and never pends.
module imsic_intp_file_rx #(
  parameter int NR_IDS     = 63,
  parameter int NR_IDS_W   = $clog2(NR_IDS + 1),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                ni_rst,
  input  logic                i_msi_valid,
  output logic                o_msi_ready,
  input  logic [11:0]         i_msi_off,
  input  logic [31:0]         i_msi_data,
  input  logic                i_eidelivery,
  input  logic [NR_IDS_W-1:0] i_eithreshold,
  input  logic [NR_IDS:0]     i_eie,
  input  logic                i_claim,
  output logic [NR_IDS_W-1:0] o_topei,
  output logic                o_xeip,
  output logic [NR_IDS:0]     o_eip,
  output logic [15:0]         o_drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [10:0] MAX_ID = 11'(NR_IDS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [NR_IDS_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NR_IDS:0]     eip_q, eip_d;
  logic [NR_IDS_W-1:0] topei_q, topei_d;
  logic                xeip_q, xeip_d;
  logic [15:0]         drop_q;

  logic [31:0] swapped;
  logic [10:0] id_raw;
  logic        legal, hs, push, pop;

  assign o_msi_ready = cnt_q < DEPTH_C;
  assign swapped = {i_msi_data[7:0], i_msi_data[15:8],
                    i_msi_data[23:16], i_msi_data[31:24]};

  always_comb begin
    id_raw = '0;
    legal  = 1'b0;
    unique case (1'b1)
      (i_msi_off == 12'h000): begin
        id_raw = i_msi_data[10:0];
        legal  = 1'b1;
      end
      (i_msi_off == 12'h004): begin
        id_raw = swapped[10:0];
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (id_raw == '0 || id_raw > MAX_ID) legal = 1'b0;
  end

  assign hs   = i_msi_valid && o_msi_ready;
  assign push = hs && legal;
  assign pop  = cnt_q != '0;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A FIFO set on the claimed id wins over the claim clear.
  always_comb begin
    eip_d = eip_q;
    if (i_claim && topei_q != '0) eip_d[topei_q] = 1'b0;
    if (pop) eip_d[fifo_q[rd_ptr_q]] = 1'b1;
    eip_d[0] = 1'b0;
  end

  // Downward scan leaves the lowest qualifying id.
  always_comb begin
    topei_d = '0;
    for (int i = NR_IDS; i >= 1; i--) begin
      if (eip_q[i] && i_eie[i] &&
          (i_eithreshold == '0 || NR_IDS_W'(i) < i_eithreshold))
        topei_d = NR_IDS_W'(i);
    end
    xeip_d = i_eidelivery && (topei_d != '0);
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      eip_q    <= '0;
      topei_q  <= '0;
      xeip_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= id_raw[NR_IDS_W-1:0];
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      eip_q   <= eip_d;
      topei_q <= topei_d;
      xeip_q  <= xeip_d;
      if (hs && !legal && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign o_topei    = topei_q;
  assign o_xeip     = xeip_q;
  assign o_eip      = eip_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_imsic_intp_file_rx.sv
// Bench for imsic_intp_file_rx: directed scenarios plus random traffic
// against a queue-based behavioural model of the interrupt file.
module tb_imsic_intp_file_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [11:0] off = '0;
  logic [31:0] data = '0;
  logic        eidel = 1'b0;
  logic [5:0]  thr = '0;
  logic [63:0] eie = '0;
  logic        claim = 1'b0;
  logic        ready;
  logic [5:0]  topei;
  logic        xeip;
  logic [63:0] eip;
  logic [15:0] drop;

  int n_chk = 0;
  int n_pass = 0;

  int          mq[$];
  logic [63:0] m_eip;
  int          m_top;
  bit          m_xeip;
  int          m_drop;
  bit          m_acc;

  imsic_intp_file_rx dut (
    .i_clk(clk), .ni_rst(rst_n),
    .i_msi_valid(valid), .o_msi_ready(ready),
    .i_msi_off(off), .i_msi_data(data),
    .i_eidelivery(eidel), .i_eithreshold(thr),
    .i_eie(eie), .i_claim(claim),
    .o_topei(topei), .o_xeip(xeip),
    .o_eip(eip), .o_drop_cnt(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int sel(logic [63:0] e, logic [63:0] en, int t);
    for (int i = 1; i <= 63; i++)
      if (e[i] && en[i] && (t == 0 || i < t)) return i;
    return 0;
  endfunction

  function automatic int decode(logic [11:0] o, logic [31:0] d);
    int id;
    if (o == 12'h000) id = int'(d & 32'h7FF);
    else if (o == 12'h004) id = int'({d[7:0], d[15:8], d[23:16], d[31:24]} & 32'h7FF);
    else return -1;
    if (id == 0 || id > 63) return -1;
    return id;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_eip = '0; m_top = 0; m_xeip = 0; m_drop = 0; m_acc = 0;
  endtask

  task automatic model_edge();
    bit rdy;
    int nt, id;
    logic [63:0] ne;
    rdy = mq.size() < DEPTH;
    nt = sel(m_eip, eie, int'(thr));
    ne = m_eip;
    if (claim && m_top != 0) ne[m_top] = 1'b0;
    if (mq.size() != 0) begin
      ne[mq[0]] = 1'b1;
      void'(mq.pop_front());
    end
    m_acc = valid && rdy;
    if (m_acc) begin
      id = decode(off, data);
      if (id > 0) mq.push_back(id);
      else if (m_drop < 65535) m_drop++;
    end
    m_eip = ne;
    m_top = nt;
    m_xeip = eidel && nt != 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", ready, 64'(mq.size() < DEPTH));
    chk("eip", eip, m_eip);
    chk("topei", topei, 64'(m_top));
    chk("xeip", xeip, 64'(m_xeip));
    chk("drop", drop, 64'(m_drop));
  endtask

  task automatic send(logic [11:0] o, logic [31:0] d);
    int n;
    valid = 1'b1; off = o; data = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 20);
    if (!m_acc) chk("send_timeout", 64'(n), 64'(0));
    valid = 1'b0;
  endtask

  task automatic do_claim();
    claim = 1'b1;
    tick();
    claim = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk) rst_n = 1'b1;
    #1;
  endtask

  task automatic reset_checks(string p);
    chk({p, "_topei"}, topei, 0);
    chk({p, "_xeip"}, xeip, 0);
    chk({p, "_eip"}, eip, 0);
    chk({p, "_drop"}, drop, 0);
    chk({p, "_ready"}, ready, 1);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #10;
    reset_checks("rst");
    @(negedge clk) rst_n = 1'b1;
    #1;
    eie = '1; eidel = 1'b1; thr = '0;

    send(12'h000, 32'h5);
    tick();
    chk("le_eip5", eip[5], 1);
    tick();
    chk("le_topei", topei, 5);
    chk("le_xeip", xeip, 1);

    send(12'h004, 32'h0700_0000);
    tick(); tick();
    chk("be_eip7", eip[7], 1);
    send(12'h008, 32'h0);
    send(12'h000, 32'd64);
    tick(); tick();
    chk("drop2", drop, 2);
    chk("drop_eip", eip, 64'hA0);
    do_claim();
    do_claim();
    chk("cleared", eip, 0);

    send(12'h000, 32'd3);
    send(12'h000, 32'd9);
    send(12'h000, 32'd12);
    tick(); tick(); tick();
    chk("pri_thr0", topei, 3);
    thr = 6'd10;
    tick();
    chk("pri_thr10", topei, 3);
    do_claim();
    chk("claim_9", topei, 9);
    do_claim();
    chk("claim_0", topei, 0);
    chk("eip12_held", eip[12], 1);
    chk("xeip_none", xeip, 0);
    thr = '0;
    tick(); tick();
    chk("thr_off_12", topei, 12);
    eidel = 1'b0;
    tick();
    chk("deliv_off", xeip, 0);
    chk("deliv_off_top", topei, 12);
    eidel = 1'b1;
    do_claim();

    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; off = 12'h000; data = 32'(20 + i);
      tick();
    end
    valid = 1'b0;
    repeat (6) tick();
    chk("bp_all", eip[24:20], 64'h1F);

    do_reset();
    send(12'h000, 32'd5);
    tick(); tick();
    chk("col_top", topei, 5);
    valid = 1'b1; off = 12'h000; data = 32'd5;
    tick();
    valid = 1'b0;
    claim = 1'b1;
    tick();
    claim = 1'b0;
    chk("col_eip5", eip[5], 1);
    tick(); tick();
    chk("col_top_after", topei, 5);

    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; off = 12'h000; data = 32'(30 + i);
      tick();
    end
    #2 rst_n = 1'b0;
    valid = 1'b0;
    model_reset();
    #1;
    reset_checks("arst");
    @(negedge clk) rst_n = 1'b1;
    #1;

    for (int c = 0; c < 400; c++) begin
      if (!valid || m_acc) begin
        valid = ($urandom_range(0, 9) < 6);
        case ($urandom_range(0, 5))
          0: off = 12'h004;
          1: off = 12'(($urandom_range(1, 1023)) * 4);
          default: off = 12'h000;
        endcase
        data = (off == 12'h004) ? {8'($urandom_range(0, 70)), 24'h0}
                                : 32'($urandom_range(0, 70));
      end
      if ($urandom_range(0, 15) == 0) eie = {$urandom, $urandom} | {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0)
        thr = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
      if ($urandom_range(0, 19) == 0) eidel = ~eidel;
      claim = ($urandom_range(0, 3) == 0);
      tick();
    end
    valid = 1'b0;
    claim = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
